// File: rtl/gsram_pkg.sv
// Shared types for the gSRAM scan reader: default geometry, index/element types and FSM states.
package gsram_pkg;

  localparam int DEF_ROWS = 10;
  localparam int DEF_COLS = 10;
  localparam int DEF_DW   = 16;

  typedef logic [3:0] idx_t;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    idx_t              row;
    idx_t              col;
    logic              last;
  } scan_elem_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/gsram_scan_fifo.sv
// Two-entry FIFO of tagged scan elements; head is read straight from storage so it
// stays stable while the consumer stalls.
module gsram_scan_fifo
  import gsram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  scan_elem_t push_elem,
  input  logic       pop,
  output scan_elem_t head,
  output logic       full,
  output logic       empty
);

  scan_elem_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_elem;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gsram_scan_reader.sv
// Read-side sequencer: scans every gSRAM element and streams it out over valid/ready.
// Define GSRAM_SCAN_TRANSPOSE_EN for a column-major scan order.
module gsram_scan_reader
  import gsram_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sram_we,
  output logic [3:0]    sram_row,
  output logic [3:0]    sram_col,
  input  logic [DW-1:0] sram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_row,
  output logic [3:0]    out_col,
  output logic          out_last
);

  localparam idx_t ROW_MAX = idx_t'(ROWS - 1);
  localparam idx_t COL_MAX = idx_t'(COLS - 1);

  scan_state_t state;
  idx_t        nxt_row, nxt_col;
  idx_t        last_row, last_col;
  idx_t        infl_row, infl_col;
  logic        infl_v, infl_last;
  logic        at_end, issue, pop;
  logic        fifo_full, fifo_empty;
  logic [2:0]  load;
  scan_elem_t  head, push_elem;

  // Entries already buffered or on their way back, with the head counted as gone if it leaves now.
  assign load   = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1)) + {2'b00, infl_v};
  assign pop    = out_valid && out_ready;
  assign at_end = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
  assign issue  = (state == SCAN) && (load < (3'd2 + {2'b00, pop}));

  assign sram_we  = 1'b0;
  assign sram_row = issue ? nxt_row : last_row;
  assign sram_col = issue ? nxt_col : last_col;

  assign push_elem = '{data: sram_rdata, row: infl_row, col: infl_col, last: infl_last};

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_last  = head.last;

  gsram_scan_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_v),
    .push_elem (push_elem),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM, address counters and the tag of the read whose data arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      nxt_row   <= '0;
      nxt_col   <= '0;
      last_row  <= '0;
      last_col  <= '0;
      infl_v    <= 1'b0;
      infl_row  <= '0;
      infl_col  <= '0;
      infl_last <= 1'b0;
    end else begin
      done   <= 1'b0;
      infl_v <= issue;
      if (issue) begin
        last_row  <= nxt_row;
        last_col  <= nxt_col;
        infl_row  <= nxt_row;
        infl_col  <= nxt_col;
        infl_last <= at_end;
        if (!at_end) begin
`ifdef GSRAM_SCAN_TRANSPOSE_EN
          if (nxt_row == ROW_MAX) begin
            nxt_row <= '0;
            nxt_col <= nxt_col + idx_t'(1);
          end else begin
            nxt_row <= nxt_row + idx_t'(1);
          end
`else
          if (nxt_col == COL_MAX) begin
            nxt_col <= '0;
            nxt_row <= nxt_row + idx_t'(1);
          end else begin
            nxt_col <= nxt_col + idx_t'(1);
          end
`endif
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            nxt_row <= '0;
            nxt_col <= '0;
          end
        end
        SCAN: begin
          if (issue && at_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
